// File: rtl/regfile_pkg.sv
// Shared constants for the register file, decode and writeback stages.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int ZERO_REG      = 0;

    // Address width for a register file of the given depth (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one pending-writeback bit per register.
// An issue sets the bit, a write clears it, and an issue on the same edge wins.
// Entry 0 is never busy. Each read port sees the busy bit of its address.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  DEPTH    = DEFAULT_DEPTH,
    parameter int  NUM_READ = 2,
    localparam int AW       = addr_w(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   set_en,
    input  logic [AW-1:0]          set_idx,
    input  logic                   clr_en,
    input  logic [AW-1:0]          clr_idx,
    input  logic [NUM_READ*AW-1:0] rd_idx,
    output logic [NUM_READ-1:0]    busy_rd
);

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;

    // Next busy vector: set has priority over clear, entry 0 pinned to idle.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int r = 0; r < DEPTH; r++) begin
            if (r == ZERO_REG) begin
                busy_nxt_s[r] = 1'b0;
            end else if (set_en && (set_idx == AW'(r))) begin
                busy_nxt_s[r] = 1'b1;
            end else if (clr_en && (clr_idx == AW'(r))) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
    end

    // Busy vector register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Per-port busy lookup, combinational.
    for (genvar p = 0; p < NUM_READ; p++) begin : g_busy_rd
        assign busy_rd[p] = busy_r[rd_idx[p*AW +: AW]];
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: DEPTH x WIDTH storage, NUM_READ combinational
// read ports, one write port, busy scoreboard and a debug tap on TAP_REG.
// Register 0 reads as zero and is never busy.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN -- a read (or the tap) that
// matches the active write address returns the write data in the same cycle.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int  WIDTH    = DEFAULT_WIDTH,
    parameter int  DEPTH    = DEFAULT_DEPTH,
    parameter int  NUM_READ = 2,
    parameter int  TAP_REG  = 1,
    localparam int AW       = addr_w(DEPTH)
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic                      ctrl_writeEnable,
    input  logic [AW-1:0]             ctrl_writeReg,
    input  logic [WIDTH-1:0]          data_writeReg,
    input  logic [NUM_READ*AW-1:0]    ctrl_readReg,
    output logic [NUM_READ*WIDTH-1:0] data_readReg,
    input  logic                      ctrl_issue,
    input  logic [AW-1:0]             ctrl_issueReg,
    output logic [NUM_READ-1:0]       busy_read,
    output logic [WIDTH-1:0]          data_tap
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW-1:0] TAP_ADDR  = AW'(TAP_REG);

    logic [WIDTH-1:0]    regs_r [DEPTH];
    logic                wr_en_s;
    logic [NUM_READ-1:0] sb_busy_s;

    // Writes to register 0 are dropped here so it never holds data.
    assign wr_en_s = ctrl_writeEnable && (ctrl_writeReg != ZERO_ADDR);

    // Storage update: reset clears every entry, a qualified write commits one entry.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_r[ctrl_writeReg] <= data_writeReg;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ)
    ) u_scoreboard (
        .clock   (clock),
        .reset   (ctrl_reset),
        .set_en  (ctrl_issue),
        .set_idx (ctrl_issueReg),
        .clr_en  (ctrl_writeEnable),
        .clr_idx (ctrl_writeReg),
        .rd_idx  (ctrl_readReg),
        .busy_rd (sb_busy_s)
    );

    // Read ports: independent combinational muxes, register 0 forced to zero.
    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [AW-1:0]    addr_s;
        logic [WIDTH-1:0] stored_s;

        assign addr_s   = ctrl_readReg[p*AW +: AW];
        assign stored_s = (addr_s == ZERO_ADDR) ? '0 : regs_r[addr_s];

`ifdef REGFILE_WRITE_BYPASS_EN
        logic hit_s;

        // A matching write is already resolved, so only a same-cycle issue keeps it busy.
        assign hit_s                          = wr_en_s && (addr_s == ctrl_writeReg);
        assign data_readReg[p*WIDTH +: WIDTH] = hit_s ? data_writeReg : stored_s;
        assign busy_read[p]                   = hit_s ? (ctrl_issue && (ctrl_issueReg == addr_s))
                                                      : sb_busy_s[p];
`else
        assign data_readReg[p*WIDTH +: WIDTH] = stored_s;
        assign busy_read[p]                   = sb_busy_s[p];
`endif
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    assign data_tap = (wr_en_s && (ctrl_writeReg == TAP_ADDR)) ? data_writeReg : regs_r[TAP_REG];
`else
    assign data_tap = regs_r[TAP_REG];
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: array-level reference model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_regfile_param;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 32;
    localparam int NUM_READ = 2;
    localparam int TAP_REG  = 1;
    localparam int AW       = 5;

    logic                      clock = 1'b0;
    logic                      ctrl_reset;
    logic                      ctrl_writeEnable;
    logic [AW-1:0]             ctrl_writeReg;
    logic [WIDTH-1:0]          data_writeReg;
    logic [NUM_READ*AW-1:0]    ctrl_readReg;
    logic [NUM_READ*WIDTH-1:0] data_readReg;
    logic                      ctrl_issue;
    logic [AW-1:0]             ctrl_issueReg;
    logic [NUM_READ-1:0]       busy_read;
    logic [WIDTH-1:0]          data_tap;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [WIDTH-1:0] mem_m  [DEPTH];
    logic             busy_m [DEPTH];

    regfile_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NUM_READ (NUM_READ),
        .TAP_REG  (TAP_REG)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readReg     (ctrl_readReg),
        .data_readReg     (data_readReg),
        .ctrl_issue       (ctrl_issue),
        .ctrl_issueReg    (ctrl_issueReg),
        .busy_read        (busy_read),
        .data_tap         (data_tap)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected read data for an address given the model contents and current inputs.
    function automatic logic [WIDTH-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (ctrl_writeEnable && (ctrl_writeReg == a)) return data_writeReg;
`endif
        return mem_m[a];
    endfunction

    // Expected busy flag for an address given the model scoreboard and current inputs.
    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (ctrl_writeEnable && (ctrl_writeReg == a)) return ctrl_issue && (ctrl_issueReg == a);
`endif
        return busy_m[a];
    endfunction

    // Reference model: reset clears everything, write stores and frees, issue marks busy last.
    always @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_m[i]  <= '0;
                busy_m[i] <= 1'b0;
            end
        end else begin
            if (ctrl_writeEnable && (ctrl_writeReg != 0)) begin
                mem_m[ctrl_writeReg]  <= data_writeReg;
                busy_m[ctrl_writeReg] <= 1'b0;
            end
            if (ctrl_issue && (ctrl_issueReg != 0)) begin
                busy_m[ctrl_issueReg] <= 1'b1;
            end
        end
    end

    // Compare every output against the model midway through each cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int p = 0; p < NUM_READ; p++) begin
                logic [AW-1:0] a;
                a = ctrl_readReg[p*AW +: AW];
                check("model_read_data", data_readReg[p*WIDTH +: WIDTH], exp_data(a));
                check("model_busy_read", WIDTH'(busy_read[p]), WIDTH'(exp_busy(a)));
            end
            check("model_data_tap", data_tap, exp_data(AW'(TAP_REG)));
        end
    end

    // One stimulus cycle: apply inputs after the edge, return at the following negedge.
    task automatic cyc(input logic rst, input logic we, input logic [AW-1:0] wr,
                       input logic [WIDTH-1:0] wd, input logic iss, input logic [AW-1:0] ir,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        @(posedge clock);
        #1;
        ctrl_reset       = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_issue       = iss;
        ctrl_issueReg    = ir;
        ctrl_readReg     = {ra1, ra0};
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        ctrl_reset       = 1'b1;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        ctrl_issue       = 1'b0;
        ctrl_issueReg    = '0;
        ctrl_readReg     = '0;
        @(posedge clock);
        #1;
        chk_en = 1'b1;

        // Reset clears stored data, also overriding a same-cycle write and issue.
        cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5);
        cyc(1'b1, 1'b1, 5'd6, 32'h00001111, 1'b1, 5'd6, 5'd5, 5'd6);
        check("r5_before_reset", data_readReg[31:0], 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
        check("reset_r5", data_readReg[31:0], 32'h0);
        check("reset_r6", data_readReg[63:32], 32'h0);
        check("reset_busy", WIDTH'(busy_read), 32'h0);
        check("reset_tap", data_tap, 32'h0);

        // Register 0 ignores writes and issues.
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("r0_data", data_readReg[31:0], 32'h0);
        check("r0_busy", WIDTH'(busy_read), 32'h0);

        // Write then read the same register on both ports.
        cyc(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
        check("r7_port0", data_readReg[31:0], 32'h12345678);
        check("r7_port1", data_readReg[63:32], 32'h12345678);

        // Scoreboard: issue, issue+write (set wins), write alone clears.
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
        cyc(1'b0, 1'b1, 5'd3, 32'h00000033, 1'b1, 5'd3, 5'd3, 5'd3);
        check("r3_busy_after_issue", WIDTH'(busy_read[0]), 32'h1);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
        check("r3_busy_set_wins", WIDTH'(busy_read[0]), 32'h1);
        cyc(1'b0, 1'b1, 5'd3, 32'h00000044, 1'b0, 5'd0, 5'd3, 5'd3);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        check("r3_busy_cleared", WIDTH'(busy_read), 32'h0);
        check("r3_data", data_readReg[31:0], 32'h00000044);
        cyc(1'b0, 1'b1, 5'd4, 32'h00000055, 1'b0, 5'd0, 5'd4, 5'd4);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        check("r4_write_not_busy", WIDTH'(busy_read), 32'h0);

        // Tap follows register 1 and ignores writes elsewhere.
        cyc(1'b0, 1'b1, 5'd1, 32'h0000002A, 1'b0, 5'd0, 5'd1, 5'd2);
        cyc(1'b0, 1'b1, 5'd2, 32'h00000099, 1'b0, 5'd0, 5'd1, 5'd2);
        check("tap_r1", data_tap, 32'h0000002A);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
        check("tap_after_r2_write", data_tap, 32'h0000002A);
        check("r2_data", data_readReg[63:32], 32'h00000099);

        // Same-cycle read of a register being written.
        cyc(1'b0, 1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 5'd0, 5'd0);
        cyc(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 5'd9, 5'd9);
`ifdef REGFILE_WRITE_BYPASS_EN
        check("r9_same_cycle", data_readReg[31:0], 32'hCAFEF00D);
`else
        check("r9_same_cycle", data_readReg[31:0], 32'h11111111);
`endif
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        check("r9_next_cycle", data_readReg[31:0], 32'hCAFEF00D);

        // Mixed traffic over a small address window to force collisions.
        for (int n = 0; n < 80; n++) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
